control_sequencer: RTL
======================

# control_sequencer

Multi-cycle control unit that sequences the 8-bit processor datapath: instruction memory, ALU, register file, write-back muxes and data memory. It owns the program counter and instruction register, and decodes each 8-bit instruction. It drives every datapath control input one state at a time, so a single ALU, register file and data memory serve all instruction classes.

## Interface
Parameters:
- PC_RESET, 8'h00: PC value loaded on reset.
- MEM_LAT, 1: data-memory read wait cycles (legal 1..3); cycles `rd` is held before load write-back.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; all state and outputs to reset values immediately.
- run  input  1  start request; sampled in IDLE.
- instruction  input  8  instruction-memory output for `pc_addr`.
- rs_data1  input  8  register file read data 1.
- rs_data2  input  8  register file read data 2.
- pc_addr  output  8  program counter.
- alu_op  output  2  ALU function.
- immediate  output  2  immediate field to ALU/zero extension.
- rs1_addr, rs2_addr, wr_addr  output  2 each  register file addresses.
- reg_wr_en  output  1  register write strobe.
- regWriteSrc  output  2  write-back select: 2'b00 ALU result, 2'b01 memory data.
- rd, wr  output  1 each  data-memory read / write enable.
- add  output  8  data-memory address.
- mem_wr_data  output  8  store data to data memory.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high in HALT.

## Operation
- Instruction fields: IR[7:6] class, IR[5:4] func, IR[3:2] reg A, IR[1:0] reg B / imm.
- Class 00 ALU-reg: alu_op=func, rs1=A, rs2=B, wr_addr=A, immediate=0.
- Class 01 ALU-imm: alu_op=func, rs1=A, immediate=B, wr_addr=A.
- Class 10 memory: func[1]=1 load (A <= mem[reg B]), func[1]=0 store (mem[reg B] <= reg A); func[0] reserved, ignored.
- Class 11 control: func 00 NOP; 01 JR (PC <= reg B); 10 BZ (if reg A == 0 then PC <= reg B, else PC+1); 11 HALT.
- States: IDLE, FETCH, DECODE, EXEC, MEMW, WB, HALT.
- IDLE -> FETCH when run=1; run ignored elsewhere.
- FETCH: IR <= instruction -> DECODE.
- DECODE: rs1_addr/rs2_addr driven from IR (combinational from IR, valid all states) -> EXEC.
- EXEC, ALU classes: reg_wr_en=1, regWriteSrc=00; PC+1 -> FETCH.
- EXEC, store: wr=1, add=rs_data2, mem_wr_data=rs_data1; PC+1 -> FETCH.
- EXEC, load: rd=1, add=rs_data2 latched into an address register; counter <= MEM_LAT-1 -> MEMW.
- MEMW: rd=1, add held; counter decrements; at 0 -> WB.
- WB: reg_wr_en=1, regWriteSrc=01, wr_addr=A; PC+1 -> FETCH.
- EXEC, control: PC updated per func -> FETCH; HALT -> HALT with PC unchanged.
- HALT: terminal; only reset exits.
- PC arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00. Jump targets are taken verbatim.

## Timing
- Reset values: pc_addr=PC_RESET, IR=8'h00 (so rs1/rs2/wr_addr=0), alu_op=0, immediate=0, reg_wr_en=0, regWriteSrc=00, rd=0, wr=0, add=0, mem_wr_data=0, busy=0, halted=0, state IDLE.
- Strobes reg_wr_en, wr and rd are Moore outputs of the current state, high for exactly the cycles stated; never two write strobes in one cycle.
- Cycles per instruction: ALU/store/control 3; load 4+MEM_LAT (EXEC + MEM_LAT MEMW + WB ... counted from FETCH).
- Register file writes and memory writes commit on the clk edge that ends EXEC/WB.
- Reset asserted mid-instruction aborts it: no partial write strobes after reset asserts; after release the block waits in IDLE for run.
- A BZ or JR targeting its own address loops forever (no special case).

## Configuration
- CTRL_SEQ_RETIRE_CNT_EN: when defined, adds output `retired` (16 bits), reset 0. It increments by 1 on the cycle each instruction leaves EXEC to FETCH or HALT, or leaves WB. It wraps 16'hFFFF -> 0. When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset, run=1, instruction memory at 0 holds 8'h05 (ALU-reg add, A=1, B=1): FETCH/DECODE/EXEC observed; reg_wr_en high in cycle 3 only, wr_addr=1, pc_addr goes 0 -> 1.
- Load 8'hA6 (A=1, B=2), rs_data2=8'h40, MEM_LAT=2: rd high 3 cycles with add=8'h40; WB with regWriteSrc=01, wr_addr=1; 6 cycles in total.
- Store 8'h86 (A=1, B=2), rs_data1=8'h5A, rs_data2=8'h10: one-cycle wr with add=8'h10, mem_wr_data=8'h5A; no reg_wr_en.
- BZ 8'hE6 with rs_data1=0, rs_data2=8'h20 -> PC=8'h20. With rs_data1=3 -> PC+1. JR at PC=8'hFF targeting 8'hFF loops; NOP at 8'hFF wraps PC to 8'h00.
- HALT 8'hF0: halted=1, busy=0, PC frozen, run toggling ignored; reset returns to IDLE with PC_RESET.
- Assert reset during load MEMW: rd drops to 0 in the same cycle, no WB write. With CTRL_SEQ_RETIRE_CNT_EN, retired counts 5 after five instructions and returns to 0 on reset.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FSM sequencing the 8-bit datapath.
// Optional retired-instruction counter: define CTRL_SEQ_RETIRE_CNT_EN.
module control_sequencer #(
   parameter logic [7:0] PC_RESET = 8'h00,
   parameter int         MEM_LAT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [7:0]  instruction,
   input  logic [7:0]  rs_data1,
   input  logic [7:0]  rs_data2,
   output logic [7:0]  pc_addr,
   output logic [1:0]  alu_op,
   output logic [1:0]  immediate,
   output logic [1:0]  rs1_addr,
   output logic [1:0]  rs2_addr,
   output logic [1:0]  wr_addr,
   output logic        reg_wr_en,
   output logic [1:0]  regWriteSrc,
   output logic        rd,
   output logic        wr,
   output logic [7:0]  add,
   output logic [7:0]  mem_wr_data,
   output logic        busy,
   output logic        halted
`ifdef CTRL_SEQ_RETIRE_CNT_EN
   ,
   output logic [15:0] retired
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEMW,
      WB,
      HALT
   } state_t;

   localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

   localparam logic [1:0] SRC_ALU = 2'b00;
   localparam logic [1:0] SRC_MEM = 2'b01;

   localparam logic [1:0] F_NOP  = 2'b00;
   localparam logic [1:0] F_JR   = 2'b01;
   localparam logic [1:0] F_BZ   = 2'b10;
   localparam logic [1:0] F_HALT = 2'b11;

   state_t     state;
   logic [7:0] ir;
   logic [1:0] cnt;

   logic [1:0] cls;
   logic [1:0] fn;
   logic       is_alu;
   logic       is_mem;
   logic       is_load;
   logic       is_store;
   logic       is_ctrl;
   logic [7:0] pc_plus1;

   // Field decode straight from the instruction register.
   always_comb begin
      cls      = ir[7:6];
      fn       = ir[5:4];
      is_alu   = ~ir[7];
      is_mem   = (cls == 2'b10);
      is_load  = is_mem & fn[1];
      is_store = is_mem & ~fn[1];
      is_ctrl  = (cls == 2'b11);
      pc_plus1 = pc_addr + 8'd1;
   end

   // Register-file addressing and ALU controls follow IR in every state.
   always_comb begin
      rs1_addr  = ir[3:2];
      rs2_addr  = ir[1:0];
      wr_addr   = ir[3:2];
      alu_op    = is_alu ? fn : 2'b00;
      immediate = (cls == 2'b01) ? ir[1:0] : 2'b00;
   end

   // Main sequencer; strobes are registered on entry to the state
   // in which they are asserted so they are clean Moore outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc_addr     <= PC_RESET;
         ir          <= 8'h00;
         cnt         <= 2'd0;
         reg_wr_en   <= 1'b0;
         regWriteSrc <= SRC_ALU;
         rd          <= 1'b0;
         wr          <= 1'b0;
         add         <= 8'h00;
         mem_wr_data <= 8'h00;
         busy        <= 1'b0;
         halted      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (run) begin
                  state <= FETCH;
                  busy  <= 1'b1;
               end
            end

            FETCH: begin
               ir    <= instruction;
               state <= DECODE;
            end

            DECODE: begin
               state <= EXEC;
               // Register data is stable from DECODE onward: nothing
               // writes the register file before EXEC ends.
               unique case (1'b1)
                  is_alu: begin
                     reg_wr_en   <= 1'b1;
                     regWriteSrc <= SRC_ALU;
                  end
                  is_store: begin
                     wr          <= 1'b1;
                     add         <= rs_data2;
                     mem_wr_data <= rs_data1;
                  end
                  is_load: begin
                     rd  <= 1'b1;
                     add <= rs_data2;
                  end
                  default: begin
                  end
               endcase
            end

            EXEC: begin
               reg_wr_en   <= 1'b0;
               wr          <= 1'b0;
               mem_wr_data <= 8'h00;
               if (is_load) begin
                  // rd and add stay asserted through MEMW.
                  cnt   <= LAT_M1;
                  state <= MEMW;
               end else if (is_ctrl) begin
                  add <= 8'h00;
                  unique case (fn)
                     F_NOP: begin
                        pc_addr <= pc_plus1;
                        state   <= FETCH;
                     end
                     F_JR: begin
                        pc_addr <= rs_data2;
                        state   <= FETCH;
                     end
                     F_BZ: begin
                        pc_addr <= (rs_data1 == 8'h00)
                                 ? rs_data2 : pc_plus1;
                        state   <= FETCH;
                     end
                     F_HALT: begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                     end
                     default: begin
                        state <= FETCH;
                     end
                  endcase
               end else begin
                  add     <= 8'h00;
                  pc_addr <= pc_plus1;
                  state   <= FETCH;
               end
            end

            MEMW: begin
               if (cnt == 2'd0) begin
                  rd          <= 1'b0;
                  add         <= 8'h00;
                  reg_wr_en   <= 1'b1;
                  regWriteSrc <= SRC_MEM;
                  state       <= WB;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end

            WB: begin
               reg_wr_en   <= 1'b0;
               regWriteSrc <= SRC_ALU;
               pc_addr     <= pc_plus1;
               state       <= FETCH;
            end

            HALT: begin
               state <= HALT;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CTRL_SEQ_RETIRE_CNT_EN
   logic retire_now;

   // An instruction retires when it leaves EXEC (non-load) or WB.
   always_comb begin
      retire_now = ((state == EXEC) && !is_load) || (state == WB);
   end

   // Free-running retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired <= 16'h0000;
      end else if (retire_now) begin
         retired <= retired + 16'd1;
      end
   end
`endif

endmodule
